// File: rtl/bp_me_cfg_boot_master_pkg.sv
// Shared types and constants for the tile cfg boot master: BedRock mem header,
// cfg register map, FSM/item encodings and the cfg address builder.
package bp_me_cfg_boot_master_pkg;

  localparam int paddr_w     = 40;
  localparam int cord_w      = 8;
  localparam int cfg_dev_w   = 4;
  localparam int cfg_off_w   = paddr_w - cord_w - cfg_dev_w;
  localparam int dword_w     = 64;
  localparam int cce_instr_w = 48;
  localparam int cce_pc_w    = 8;
  localparam int lce_id_w    = 8;

  localparam logic [cfg_dev_w-1:0] cfg_dev_gp                  = 4'h2;
  localparam logic [cfg_off_w-1:0] cfg_reg_freeze_gp           = 28'h000_0008;
  localparam logic [cfg_off_w-1:0] cfg_reg_cce_mode_gp         = 28'h000_0010;
  localparam logic [cfg_off_w-1:0] cfg_reg_icache_mode_gp      = 28'h000_0018;
  localparam logic [cfg_off_w-1:0] cfg_reg_dcache_mode_gp      = 28'h000_0020;
  localparam logic [cfg_off_w-1:0] cfg_reg_hio_mask_gp         = 28'h000_0028;
  localparam logic [cfg_off_w-1:0] cfg_mem_cce_ucode_match_gp  = 28'h000_8000;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6
  } bp_bedrock_msg_size_e;

  typedef enum logic [2:0] {
    e_lce_mode_uncached = 3'd0,
    e_lce_mode_normal   = 3'd1,
    e_lce_mode_nonspec  = 3'd2
  } bp_lce_mode_e;

  typedef enum logic [2:0] {
    e_cce_mode_normal   = 3'd0,
    e_cce_mode_uncached = 3'd1
  } bp_cce_mode_e;

  typedef struct packed {
    logic [lce_id_w-1:0]  lce_id;
    logic [paddr_w-1:0]   addr;
    bp_bedrock_msg_size_e size;
    bp_bedrock_mem_type_e msg_type;
  } bp_bedrock_mem_hdr_s;

  typedef enum logic [2:0] {
    e_reset, e_send, e_wait, e_rom_rd, e_rom_cap, e_done
  } bp_me_cfg_boot_state_e;

  // Boot items in issue order; the ucode item repeats once per ROM word.
  typedef enum logic [2:0] {
    e_item_freeze, e_item_cce_mode, e_item_icache, e_item_dcache,
    e_item_hio, e_item_ucode, e_item_unfreeze
  } bp_me_cfg_boot_item_e;

  // Physical address of a cfg register in the tile at the given cord.
  function automatic logic [paddr_w-1:0] bp_me_cfg_addr(input logic [cord_w-1:0]    cord,
                                                        input logic [cfg_off_w-1:0] reg_offset);
    return {cord, cfg_dev_gp, reg_offset};
  endfunction

endpackage

// File: rtl/bp_me_cfg_boot_master_if.sv
// Single-beat BedRock mem cmd/resp channel pair between a cfg initiator and the cfg responder.
interface bp_me_cfg_boot_master_if;
  import bp_me_cfg_boot_master_pkg::*;

  bp_bedrock_mem_hdr_s  mem_cmd_header;
  logic [dword_w-1:0]   mem_cmd_data;
  logic                 mem_cmd_v;
  logic                 mem_cmd_ready_and;
  logic                 mem_cmd_last;

  bp_bedrock_mem_hdr_s  mem_resp_header;
  logic [dword_w-1:0]   mem_resp_data;
  logic                 mem_resp_v;
  logic                 mem_resp_ready_and;
  logic                 mem_resp_last;

  modport master (
    output mem_cmd_header, mem_cmd_data, mem_cmd_v, mem_cmd_last, mem_resp_ready_and,
    input  mem_cmd_ready_and, mem_resp_header, mem_resp_data, mem_resp_v, mem_resp_last
  );

  modport slave (
    input  mem_cmd_header, mem_cmd_data, mem_cmd_v, mem_cmd_last, mem_resp_ready_and,
    output mem_cmd_ready_and, mem_resp_header, mem_resp_data, mem_resp_v, mem_resp_last
  );

endinterface

// File: rtl/bp_me_cfg_boot_master.sv
// Boot-time cfg initiator: freezes the tile, programs modes and hio mask, loads (and
// optionally verifies) the CCE ucode from an external ROM, unfreezes, then reports done.
module bp_me_cfg_boot_master
  import bp_me_cfg_boot_master_pkg::*;
#(
  parameter int                 ucode_els_p    = 256,
  parameter bp_lce_mode_e       icache_mode_p  = e_lce_mode_normal,
  parameter bp_lce_mode_e       dcache_mode_p  = e_lce_mode_normal,
  parameter bp_cce_mode_e       cce_mode_p     = e_cce_mode_normal,
  parameter logic [dword_w-1:0] hio_mask_p     = '0,
  parameter bit                 verify_ucode_p = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [cord_w-1:0]       cord_i,
  bp_me_cfg_boot_master_if.master mem_if,
  output logic                    ucode_v_o,
  output logic [cce_pc_w-1:0]     ucode_addr_o,
  input  logic [cce_instr_w-1:0]  ucode_data_i,
  output logic                    done_o,
  output logic                    error_o
);

  // One extra bit so the last index of a full 2^cce_pc_w image never wraps.
  localparam int                idx_w    = $clog2(ucode_els_p + 1);
  localparam logic [idx_w-1:0]  idx_last = idx_w'(ucode_els_p - 1);

  bp_me_cfg_boot_state_e    state_q, state_d;
  bp_me_cfg_boot_item_e     item_q, item_d;
  logic [idx_w-1:0]         idx_q, idx_d;
  logic                     rd_q, rd_d;       // current ucode cmd is the readback
  logic [cce_instr_w-1:0]   instr_q, instr_d;
  logic                     error_q, error_d;

  bp_bedrock_mem_type_e     exp_type;
  logic                     resp_bad;
  logic [cfg_off_w-1:0]     cmd_off;
  bp_bedrock_mem_hdr_s      cmd_hdr;
  logic [dword_w-1:0]       cmd_data;

  assign exp_type = rd_q ? e_bedrock_mem_uc_rd : e_bedrock_mem_uc_wr;
  assign resp_bad = (mem_if.mem_resp_header.msg_type != exp_type)
                  | ~mem_if.mem_resp_last
                  | (rd_q & (mem_if.mem_resp_data[cce_instr_w-1:0] != instr_q));

  // State register; async reset restarts the whole sequence from the freeze write.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_reset;
      item_q  <= e_item_freeze;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      instr_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      instr_q <= instr_d;
      error_q <= error_d;
    end
  end

  // Next state: one cmd in flight, advance to the next item on each consumed resp.
  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    instr_d = instr_q;
    error_d = error_q;
    case (state_q)
      e_reset:   state_d = e_send;
      e_send:    if (mem_if.mem_cmd_ready_and) state_d = e_wait;
      e_wait: begin
        if (mem_if.mem_resp_v) begin
          error_d = error_q | resp_bad;
          if (item_q == e_item_ucode) begin
            if (verify_ucode_p && !rd_q) begin
              rd_d    = 1'b1;
              state_d = e_send;
            end else begin
              rd_d = 1'b0;
              if (idx_q == idx_last) begin
                item_d  = e_item_unfreeze;
                state_d = e_send;
              end else begin
                idx_d   = idx_q + idx_w'(1);
                state_d = e_rom_rd;
              end
            end
          end else if (item_q == e_item_unfreeze) begin
            state_d = e_done;
          end else begin
            item_d  = bp_me_cfg_boot_item_e'(item_q + 3'd1);
            state_d = (item_q == e_item_hio) ? e_rom_rd : e_send;
          end
        end
      end
      e_rom_rd:  state_d = e_rom_cap;
      e_rom_cap: begin
        instr_d = ucode_data_i;
        state_d = e_send;
      end
      e_done:    if (mem_if.mem_resp_v) error_d = 1'b1;
      default:   state_d = e_reset;
    endcase
  end

  // Outputs: handshake strobes from state, cmd header/data from the current item.
  always_comb begin
    cmd_off  = cfg_reg_freeze_gp;
    cmd_data = '0;
    case (item_q)
      e_item_freeze:   begin cmd_off = cfg_reg_freeze_gp;      cmd_data = dword_w'(1);             end
      e_item_cce_mode: begin cmd_off = cfg_reg_cce_mode_gp;    cmd_data = dword_w'(cce_mode_p);    end
      e_item_icache:   begin cmd_off = cfg_reg_icache_mode_gp; cmd_data = dword_w'(icache_mode_p); end
      e_item_dcache:   begin cmd_off = cfg_reg_dcache_mode_gp; cmd_data = dword_w'(dcache_mode_p); end
      e_item_hio:      begin cmd_off = cfg_reg_hio_mask_gp;    cmd_data = hio_mask_p;              end
      e_item_ucode: begin
        cmd_off  = cfg_mem_cce_ucode_match_gp + (cfg_off_w'(idx_q) << 3);
        cmd_data = rd_q ? '0 : dword_w'(instr_q);
      end
      e_item_unfreeze: begin cmd_off = cfg_reg_freeze_gp;      cmd_data = '0;                      end
      default: ;
    endcase

    cmd_hdr          = '0;
    cmd_hdr.msg_type = rd_q ? e_bedrock_mem_uc_rd : e_bedrock_mem_uc_wr;
    cmd_hdr.size     = e_bedrock_msg_size_8;
    cmd_hdr.addr     = bp_me_cfg_addr(cord_i, cmd_off);

    mem_if.mem_cmd_header     = cmd_hdr;
    mem_if.mem_cmd_data       = cmd_data;
    mem_if.mem_cmd_v          = (state_q == e_send);
    mem_if.mem_cmd_last       = 1'b1;
    mem_if.mem_resp_ready_and = (state_q == e_wait) || (state_q == e_done);
    ucode_v_o                 = (state_q == e_rom_rd);
    ucode_addr_o              = cce_pc_w'(idx_q);
    done_o                    = (state_q == e_done);
    error_o                   = error_q;
  end

endmodule
